// File: rtl/spi_master_dual_if.sv
// Bus bundle for the dual-lane SPI master: frame request/data in, serial lines
// and frame status out. The master modport is the SPI master's own view.
interface spi_master_dual_if;
    logic        start;
    logic [31:0] tx_data0;
    logic [31:0] tx_data1;
    logic        SCK;
    logic        SSEL;
    logic        DATA_OUT0;
    logic        DATA_OUT1;
    logic        busy;
    logic        done;
    logic [31:0] tx_count;

    modport master (
        input  start, tx_data0, tx_data1,
        output SCK, SSEL, DATA_OUT0, DATA_OUT1, busy, done, tx_count
    );

    modport slave (
        output start, tx_data0, tx_data1,
        input  SCK, SSEL, DATA_OUT0, DATA_OUT1, busy, done, tx_count
    );
endinterface

// File: rtl/spi_master_dual.sv
// Dual-lane SPI master: shifts two 32-bit words MSB first on two data lines
// sharing one SCK and SSEL, with a setup phase, a hold phase and an inter-frame gap.
module spi_master_dual #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input logic              clk,
    input logic              reset,
    spi_master_dual_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYC - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [30:0] rem0;
    logic [30:0] rem1;
    logic        sck_q;
    logic        ssel_q;
    logic        data0_q;
    logic        data1_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] tx_count_q;

    // The divider always counts down to zero and the event fires on the edge
    // that sees zero, so a reload of N-1 spaces events exactly N cycles apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= 8'd0;
            bit_cnt    <= 5'd0;
            rem0       <= 31'd0;
            rem1       <= 31'd0;
            sck_q      <= 1'b0;
            ssel_q     <= 1'b1;
            data0_q    <= 1'b0;
            data1_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_count_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem0    <= bus.tx_data0[30:0];
                        rem1    <= bus.tx_data1[30:0];
                        data0_q <= bus.tx_data0[31];
                        data1_q <= bus.tx_data1[31];
                        ssel_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        bit_cnt <= 5'd0;
                        div_cnt <= DIV_RELOAD;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_cnt == 8'd0) begin
                        sck_q   <= 1'b1;
                        div_cnt <= DIV_RELOAD;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                // Data only moves on falling SCK; the 32nd fall ends the frame
                // by comparing the counter, never by waiting for it to wrap.
                SHIFT: begin
                    if (div_cnt == 8'd0) begin
                        div_cnt <= DIV_RELOAD;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_cnt == 5'd31) begin
                                bit_cnt <= 5'd0;
                                state   <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                data0_q <= rem0[30];
                                data1_q <= rem1[30];
                                rem0    <= {rem0[29:0], 1'b0};
                                rem1    <= {rem1[29:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                HOLD: begin
                    if (div_cnt == 8'd0) begin
                        ssel_q  <= 1'b1;
                        data0_q <= 1'b0;
                        data1_q <= 1'b0;
                        div_cnt <= GAP_RELOAD;
                        state   <= GAP;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                GAP: begin
                    if (div_cnt == 8'd0) begin
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        tx_count_q <= tx_count_q + 32'd1;
                        div_cnt    <= DIV_RELOAD;
                        state      <= IDLE;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                default: begin
                    sck_q   <= 1'b0;
                    ssel_q  <= 1'b1;
                    data0_q <= 1'b0;
                    data1_q <= 1'b0;
                    busy_q  <= 1'b0;
                    div_cnt <= 8'd0;
                    bit_cnt <= 5'd0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.SCK       = sck_q;
    assign bus.SSEL      = ssel_q;
    assign bus.DATA_OUT0 = data0_q;
    assign bus.DATA_OUT1 = data1_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.tx_count  = tx_count_q;

endmodule
